// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the pipeline stage buffer: occupancy encodings and
// default bubble words for each inter-stage register.
package pipe_stage_buf_pkg;

   localparam int PIPE_ST_WIDTH = 2;

   localparam logic [PIPE_ST_WIDTH-1:0] PIPE_ST_EMPTY = 2'b00;
   localparam logic [PIPE_ST_WIDTH-1:0] PIPE_ST_ONE   = 2'b01;
   localparam logic [PIPE_ST_WIDTH-1:0] PIPE_ST_TWO   = 2'b10;

   // Bubble words place res-op = 2'b11 ("no result") in the low bits where a stage carries one.
   localparam logic [127:0] PIPE_BUBBLE_IF_ID  = 128'h0;
   localparam logic [127:0] PIPE_BUBBLE_ID_EX  = 128'h3;
   localparam logic [127:0] PIPE_BUBBLE_EX_MEM = 128'h3;
   localparam logic [127:0] PIPE_BUBBLE_MEM_WB = 128'h3;

   function automatic logic st_holds_beat(input logic [PIPE_ST_WIDTH-1:0] st);
      return st != PIPE_ST_EMPTY;
   endfunction

   function automatic logic st_can_accept(input logic [PIPE_ST_WIDTH-1:0] st);
      return st != PIPE_ST_TWO;
   endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with synchronous active-low clear; sticks at all ones.
module pipe_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional stall/flush statistics counters are built when ROOTH_PIPE_STAT_EN is defined.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int                DATA_W     = 128,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
`ifdef ROOTH_PIPE_STAT_EN
   ,
   parameter int                CNT_W      = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              up_valid_i,
   output logic              up_ready_o,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              dn_valid_o,
   input  logic              dn_ready_i,
   output logic [DATA_W-1:0] dn_data_o
`ifdef ROOTH_PIPE_STAT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

   logic [PIPE_ST_WIDTH-1:0] state_q;
   logic [PIPE_ST_WIDTH-1:0] state_d;
   logic [DATA_W-1:0]        main_q;
   logic [DATA_W-1:0]        main_d;
   logic [DATA_W-1:0]        skid_q;
   logic [DATA_W-1:0]        skid_d;
   logic                     up_fire;
   logic                     dn_fire;

   // Handshake outputs come straight from the state flop, so up_ready_o is registered.
   assign up_ready_o = st_can_accept(state_q);
   assign dn_valid_o = st_holds_beat(state_q);
   assign dn_data_o  = main_q;

   assign up_fire = up_valid_i & up_ready_o;
   assign dn_fire = dn_valid_o & dn_ready_i;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         // Any beat offered this cycle is dropped; a beat leaving downstream still counts.
         state_d = PIPE_ST_EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            PIPE_ST_EMPTY: begin
               if (up_fire) begin
                  state_d = PIPE_ST_ONE;
                  main_d  = up_data_i;
               end
            end
            PIPE_ST_ONE: begin
               if (up_fire && dn_fire) begin
                  main_d = up_data_i;
               end else if (up_fire) begin
                  state_d = PIPE_ST_TWO;
                  skid_d  = up_data_i;
               end else if (dn_fire) begin
                  state_d = PIPE_ST_EMPTY;
                  main_d  = BUBBLE_VAL;
               end
            end
            PIPE_ST_TWO: begin
               if (dn_fire) begin
                  state_d = PIPE_ST_ONE;
                  main_d  = skid_q;
                  skid_d  = BUBBLE_VAL;
               end
            end
            default: begin
               state_d = PIPE_ST_EMPTY;
               main_d  = BUBBLE_VAL;
               skid_d  = BUBBLE_VAL;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= PIPE_ST_EMPTY;
         main_q  <= BUBBLE_VAL;
         skid_q  <= BUBBLE_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef ROOTH_PIPE_STAT_EN
   logic stall_inc;

   assign stall_inc = dn_valid_o & ~dn_ready_i;

   pipe_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt_o)
   );

   pipe_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (flush_i),
      .cnt_o (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed vector table, then a random
// valid/ready/flush run against a queue-based reference model.
module tb_pipe_stage_buf;

   localparam int          DATA_W = 16;
   localparam logic [15:0] BUBBLE = 16'hB0BB;
   localparam int          CNT_W  = 4;

   logic              clk;
   logic              rst_n;
   logic              flush_i;
   logic              up_valid_i;
   logic              up_ready_o;
   logic [DATA_W-1:0] up_data_i;
   logic              dn_valid_o;
   logic              dn_ready_i;
   logic [DATA_W-1:0] dn_data_o;
`ifdef ROOTH_PIPE_STAT_EN
   logic [CNT_W-1:0]  stall_cnt_o;
   logic [CNT_W-1:0]  flush_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst_n;
      logic        flush;
      logic        up_valid;
      logic [15:0] up_data;
      logic        dn_ready;
      logic        exp_dn_valid;
      logic        exp_up_ready;
      logic [15:0] exp_dn_data;
   } vec_t;

   vec_t vecs[$];

   pipe_stage_buf #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL (BUBBLE)
`ifdef ROOTH_PIPE_STAT_EN
      ,
      .CNT_W      (CNT_W)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .up_valid_i  (up_valid_i),
      .up_ready_o  (up_ready_o),
      .up_data_i   (up_data_i),
      .dn_valid_o  (dn_valid_o),
      .dn_ready_i  (dn_ready_i),
      .dn_data_o   (dn_data_o)
`ifdef ROOTH_PIPE_STAT_EN
      ,
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic f, input logic uv, input logic [15:0] ud, input logic dr);
      rst_n      = r;
      flush_i    = f;
      up_valid_i = uv;
      up_data_i  = ud;
      dn_ready_i = dr;
   endtask

   task automatic addVec(input logic r, input logic f, input logic uv, input logic [15:0] ud, input logic dr,
                         input logic ev, input logic er, input logic [15:0] ed);
      vec_t v;
      v.rst_n = r; v.flush = f; v.up_valid = uv; v.up_data = ud; v.dn_ready = dr;
      v.exp_dn_valid = ev; v.exp_up_ready = er; v.exp_dn_data = ed;
      vecs.push_back(v);
   endtask

   initial begin
      logic [15:0] q[$];
      logic        uv, dr, fl, up_fire, dn_fire;
      logic [15:0] ud;
      int          delivered;
      int          exp_stall;
      int          exp_flush;

      //     rst flush uv  data     dr   -> valid ready data
      addVec(0, 0, 1, 16'h0999, 1,  0, 1, BUBBLE);   // reset with a beat offered
      addVec(1, 0, 1, 16'h0001, 1,  1, 1, 16'h0001); // stream
      addVec(1, 0, 1, 16'h0002, 1,  1, 1, 16'h0002);
      addVec(1, 0, 1, 16'h0003, 1,  1, 1, 16'h0003);
      addVec(1, 0, 0, 16'h0000, 1,  0, 1, BUBBLE);
      addVec(1, 0, 1, 16'h00AA, 0,  1, 1, 16'h00AA); // stall: A, B fill to TWO
      addVec(1, 0, 1, 16'h00BB, 0,  1, 0, 16'h00AA);
      addVec(1, 0, 1, 16'h00CC, 0,  1, 0, 16'h00AA); // not accepted while full
      addVec(1, 0, 0, 16'h0000, 1,  1, 1, 16'h00BB);
      addVec(1, 0, 0, 16'h0000, 1,  0, 1, BUBBLE);
      addVec(1, 0, 1, 16'h0011, 0,  1, 1, 16'h0011); // flush in TWO drops offered beat
      addVec(1, 0, 1, 16'h0022, 0,  1, 0, 16'h0011);
      addVec(1, 1, 1, 16'h0033, 0,  0, 1, BUBBLE);
      addVec(1, 0, 0, 16'h0000, 1,  0, 1, BUBBLE);
      addVec(1, 0, 1, 16'h0044, 1,  1, 1, 16'h0044); // flush in ONE with both fires
      addVec(1, 1, 1, 16'h0055, 1,  0, 1, BUBBLE);
      addVec(1, 0, 1, 16'h0066, 0,  1, 1, 16'h0066); // reset while in ONE
      addVec(1, 0, 0, 16'h0000, 0,  1, 1, 16'h0066);
      addVec(0, 0, 1, 16'h0077, 0,  0, 1, BUBBLE);
      addVec(1, 0, 1, 16'h0088, 0,  1, 1, 16'h0088);
      addVec(1, 0, 0, 16'h0000, 1,  0, 1, BUBBLE);

      applyStimulus(0, 0, 0, 16'h0, 0);
      @(posedge clk); #1;
      checkOutput("reset dn_valid", {15'b0, dn_valid_o}, 16'd0);
      checkOutput("reset up_ready", {15'b0, up_ready_o}, 16'd1);
      checkOutput("reset dn_data", dn_data_o, BUBBLE);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst_n, vecs[i].flush, vecs[i].up_valid, vecs[i].up_data, vecs[i].dn_ready);
         @(posedge clk); #1;
         checkOutput($sformatf("vec%0d dn_valid", i), {15'b0, dn_valid_o}, {15'b0, vecs[i].exp_dn_valid});
         checkOutput($sformatf("vec%0d up_ready", i), {15'b0, up_ready_o}, {15'b0, vecs[i].exp_up_ready});
         checkOutput($sformatf("vec%0d dn_data", i), dn_data_o, vecs[i].exp_dn_data);
      end

`ifdef ROOTH_PIPE_STAT_EN
      // Saturation: one valid beat held for 20 stalled cycles, then 3 flushes.
      applyStimulus(0, 0, 0, 16'h0, 0);
      @(posedge clk); #1;
      applyStimulus(1, 0, 1, 16'h0123, 0);
      @(posedge clk); #1;
      applyStimulus(1, 0, 0, 16'h0, 0);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("stall_cnt saturated", {12'b0, stall_cnt_o}, 16'd15);
      applyStimulus(1, 1, 0, 16'h0, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("flush_cnt after 3", {12'b0, flush_cnt_o}, 16'd3);
`endif

      // Random run against a queue model; restart from reset so counters start at zero.
      applyStimulus(0, 0, 0, 16'h0, 0);
      @(posedge clk); #1;
      delivered = 0;
      exp_stall = 0;
      exp_flush = 0;
      for (int c = 0; c < 3000; c++) begin
         uv = ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 29) == 0);
         ud = 16'(c + 1);
         applyStimulus(1, fl, uv, ud, dr);
         up_fire = uv && (q.size() < 2);
         dn_fire = (q.size() > 0) && dr;
         if (q.size() > 0 && !dr && exp_stall < 15) exp_stall++;
         if (fl && exp_flush < 15) exp_flush++;
         if (dn_fire) delivered++;
         if (fl) begin
            q.delete();
         end else begin
            if (dn_fire) void'(q.pop_front());
            if (up_fire) q.push_back(ud);
         end
         @(posedge clk); #1;
         checkOutput("rand dn_valid", {15'b0, dn_valid_o}, {15'b0, q.size() > 0});
         checkOutput("rand up_ready", {15'b0, up_ready_o}, {15'b0, q.size() < 2});
         checkOutput("rand dn_data", dn_data_o, (q.size() > 0) ? q[0] : BUBBLE);
`ifdef ROOTH_PIPE_STAT_EN
         checkOutput("rand stall_cnt", {12'b0, stall_cnt_o}, 16'(exp_stall));
         checkOutput("rand flush_cnt", {12'b0, flush_cnt_o}, 16'(exp_flush));
`endif
      end
      $display("[TB] random phase delivered %0d beats", delivered);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
